sram_d_arbiter: RTL and testbench

Two-master OBI arbiter in front of the SRAM data port. Merges the core data port (m0) and the host/loader port (m1) onto the single `sram_d_*` OBI port of the flip-flop SRAM, arbitrating round-robin. It routes read responses back in order through an outstanding-read FIFO and locally generates write responses, because the SRAM returns `rvalid` for reads only.

---
 rtl/sram_d_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_d_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_d_arbiter.sv
// Round-robin two-master OBI arbiter for the flip-flop SRAM data port.
// Read responses are routed in order via an id FIFO; write responses are generated locally.
module sram_d_arbiter #(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic        m1_req_i,
   output logic        m0_gnt_o,
   output logic        m1_gnt_o,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m1_addr_i,
   input  logic        m0_we_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m0_rvalid_o,
   output logic        m1_rvalid_o,
   output logic [31:0] m0_rdata_o,
   output logic [31:0] m1_rdata_o,
   output logic        sram_d_req_o,
   output logic [31:0] sram_d_addr_o,
   output logic        sram_d_we_o,
   output logic [3:0]  sram_d_be_o,
   output logic [31:0] sram_d_wdata_o,
   input  logic        sram_d_gnt_i,
   input  logic        sram_d_rvalid_i,
   input  logic [31:0] sram_d_rdata_i,
   output logic        protocol_err_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic             fifo_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] occ_q, occ_d, out0_q, out0_d, out1_q, out1_d;
   logic [1:0]       wr_rsp_q, wr_rsp_d;
   logic             last_q, last_d, perr_q, perr_d;

   logic pop_s, head_s, rd_ok_s, ret0_s, ret1_s, wr_ok0_s, wr_ok1_s;
   logic elig0_s, elig1_s, any_s, win_s, hs_s, push_s;

   assign pop_s    = sram_d_rvalid_i & (occ_q != {CNT_W{1'b0}});
   assign head_s   = fifo_q[rptr_q];
   assign rd_ok_s  = (occ_q != CNT_W'(DEPTH)) | pop_s;
   assign ret0_s   = pop_s & ~head_s;
   assign ret1_s   = pop_s & head_s;
   // A write may go only once its master has no read left in flight (or the last retires now).
   assign wr_ok0_s = (out0_q == {CNT_W{1'b0}}) | ((out0_q == CNT_W'(1)) & ret0_s);
   assign wr_ok1_s = (out1_q == {CNT_W{1'b0}}) | ((out1_q == CNT_W'(1)) & ret1_s);
   assign elig0_s  = m0_req_i & ~rst_i & (m0_we_i ? wr_ok0_s : rd_ok_s);
   assign elig1_s  = m1_req_i & ~rst_i & (m1_we_i ? wr_ok1_s : rd_ok_s);
   assign any_s    = elig0_s | elig1_s;
   assign win_s    = (elig0_s & elig1_s) ? ~last_q : elig1_s;
   assign hs_s     = any_s & sram_d_gnt_i;
   assign push_s   = hs_s & ~sram_d_we_o;

   assign sram_d_req_o   = any_s;
   assign m0_gnt_o       = hs_s & ~win_s;
   assign m1_gnt_o       = hs_s & win_s;
   assign m0_rvalid_o    = wr_rsp_q[0] | ret0_s;
   assign m1_rvalid_o    = wr_rsp_q[1] | ret1_s;
   assign m0_rdata_o     = ret0_s ? sram_d_rdata_i : 32'h0000_0000;
   assign m1_rdata_o     = ret1_s ? sram_d_rdata_i : 32'h0000_0000;
   assign protocol_err_o = perr_q;

   always_comb begin
      sram_d_addr_o  = 32'h0000_0000;
      sram_d_we_o    = 1'b0;
      sram_d_be_o    = 4'h0;
      sram_d_wdata_o = 32'h0000_0000;
      if (any_s & win_s) begin
         sram_d_addr_o  = m1_addr_i;
         sram_d_we_o    = m1_we_i;
         sram_d_be_o    = m1_be_i;
         sram_d_wdata_o = m1_wdata_i;
      end else if (any_s) begin
         sram_d_addr_o  = m0_addr_i;
         sram_d_we_o    = m0_we_i;
         sram_d_be_o    = m0_be_i;
         sram_d_wdata_o = m0_wdata_i;
      end else begin
         sram_d_addr_o  = 32'h0000_0000;
      end
   end

   always_comb begin
      wptr_d   = push_s ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d   = pop_s  ? rptr_q + PTR_W'(1) : rptr_q;
      occ_d    = occ_q + CNT_W'(push_s) - CNT_W'(pop_s);
      out0_d   = out0_q + CNT_W'(push_s & ~win_s) - CNT_W'(ret0_s);
      out1_d   = out1_q + CNT_W'(push_s & win_s) - CNT_W'(ret1_s);
      wr_rsp_d = {hs_s & sram_d_we_o & win_s, hs_s & sram_d_we_o & ~win_s};
      last_d   = hs_s ? win_s : last_q;
      perr_d   = sram_d_rvalid_i & (occ_q == {CNT_W{1'b0}});
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 1'b0;
         wptr_q   <= {PTR_W{1'b0}};
         rptr_q   <= {PTR_W{1'b0}};
         occ_q    <= {CNT_W{1'b0}};
         out0_q   <= {CNT_W{1'b0}};
         out1_q   <= {CNT_W{1'b0}};
         wr_rsp_q <= 2'b00;
         last_q   <= 1'b1;
         perr_q   <= 1'b0;
      end else begin
         if (push_s) fifo_q[wptr_q] <= win_s;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         occ_q    <= occ_d;
         out0_q   <= out0_d;
         out1_q   <= out1_d;
         wr_rsp_q <= wr_rsp_d;
         last_q   <= last_d;
         perr_q   <= perr_d;
      end
   end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed bench for sram_d_arbiter with a variable-latency SRAM slave model.
module tb_sram_d_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o;
   logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
   logic        m0_we_i, m1_we_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic        m0_rvalid_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        sram_d_req_o, sram_d_we_o, sram_d_gnt_i, sram_d_rvalid_i;
   logic [31:0] sram_d_addr_o, sram_d_wdata_o, sram_d_rdata_i;
   logic [3:0]  sram_d_be_o;
   logic        protocol_err_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0]  lat;
   logic [31:0] mem [16];
   bit   [8:1]  pipe_v;
   bit   [31:0] pipe_d [1:8];

   sram_d_arbiter dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
      .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
      .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
      .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
      .m0_be_i(m0_be_i), .m1_be_i(m1_be_i),
      .m0_wdata_i(m0_wdata_i), .m1_wdata_i(m1_wdata_i),
      .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
      .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
      .sram_d_req_o(sram_d_req_o), .sram_d_addr_o(sram_d_addr_o),
      .sram_d_we_o(sram_d_we_o), .sram_d_be_o(sram_d_be_o),
      .sram_d_wdata_o(sram_d_wdata_o), .sram_d_gnt_i(sram_d_gnt_i),
      .sram_d_rvalid_i(sram_d_rvalid_i), .sram_d_rdata_i(sram_d_rdata_i),
      .protocol_err_o(protocol_err_o)
   );

   always #5 clk = ~clk;

   assign sram_d_rvalid_i = pipe_v[1];
   assign sram_d_rdata_i  = pipe_d[1];

   // Slave: reads answer 'lat' cycles after handshake; the pipe survives reset so late responses appear.
   always @(posedge clk) begin
      for (int i = 1; i < 8; i++) begin
         pipe_v[i] <= pipe_v[i+1];
         pipe_d[i] <= pipe_d[i+1];
      end
      pipe_v[8] <= 1'b0;
      if (rst_i) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
         mem[4] <= 32'h1234_5678;
      end else if (sram_d_req_o && sram_d_gnt_i) begin
         if (sram_d_we_o) begin
            for (int b = 0; b < 4; b++)
               if (sram_d_be_o[b]) mem[sram_d_addr_o[5:2]][8*b +: 8] <= sram_d_wdata_o[8*b +: 8];
         end else begin
            pipe_v[lat] <= 1'b1;
            pipe_d[lat] <= mem[sram_d_addr_o[5:2]];
         end
      end
   end

   task automatic idle;
      m0_req_i = 1'b0; m1_req_i = 1'b0; m0_we_i = 1'b0; m1_we_i = 1'b0;
      m0_be_i = 4'hF; m1_be_i = 4'hF;
      m0_addr_i = 32'h0; m1_addr_i = 32'h0; m0_wdata_i = 32'h0; m1_wdata_i = 32'h0;
   endtask

   task automatic do_reset;
      @(negedge clk); rst_i = 1'b1; idle();
      @(negedge clk); rst_i = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk); rst_i = 1'b1; m0_req_i = 1'b1; m1_req_i = 1'b1; #1;
      n_cmp++; if (m0_gnt_o !== 1'b0) begin n_err++; $display("FAIL rst_gnt0: got %b want 0", m0_gnt_o); end
      n_cmp++; if (m1_gnt_o !== 1'b0) begin n_err++; $display("FAIL rst_gnt1: got %b want 0", m1_gnt_o); end
      @(negedge clk); rst_i = 1'b0; idle(); #1;
      n_cmp++; if (protocol_err_o !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", protocol_err_o); end
      n_cmp++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b%b want 00", m1_rvalid_o, m0_rvalid_o); end
      n_cmp++; if (sram_d_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", sram_d_req_o); end
   endtask

   task automatic test_single_read;
      lat = 4'd1;
      @(negedge clk); m0_req_i = 1'b1; m0_addr_i = 32'h8000_0010; #1;
      n_cmp++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin n_err++; $display("FAIL sr_gnt: got %b%b want 01", m1_gnt_o, m0_gnt_o); end
      n_cmp++; if (sram_d_addr_o !== 32'h8000_0010) begin n_err++; $display("FAIL sr_addr: got %h want 80000010", sram_d_addr_o); end
      @(negedge clk); idle(); #1;
      n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL sr_rsp: got %b/%h want 1/12345678", m0_rvalid_o, m0_rdata_o); end
      n_cmp++; if (m1_rvalid_o !== 1'b0 || m1_rdata_o !== 32'h0) begin n_err++; $display("FAIL sr_m1: got %b/%h want 0/0", m1_rvalid_o, m1_rdata_o); end
      @(negedge clk); #1;
      n_cmp++; if (m0_rvalid_o !== 1'b0) begin n_err++; $display("FAIL sr_done: got %b want 0", m0_rvalid_o); end
   endtask

   task automatic test_contention;
      logic        e0;
      logic [31:0] d0, d1;
      do_reset(); lat = 4'd1;
      m0_addr_i = 32'h8000_0020; m1_addr_i = 32'h8000_0024;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); m0_req_i = (c < 4); m1_req_i = (c < 4); #1;
         if (c < 4) begin
            e0 = (c % 2 == 0);
            n_cmp++; if (m0_gnt_o !== e0 || m1_gnt_o !== ~e0) begin n_err++; $display("FAIL ct_gnt c%0d: got %b%b want %b%b", c, m1_gnt_o, m0_gnt_o, ~e0, e0); end
         end
         if (c > 0) begin
            e0 = ((c - 1) % 2 == 0);
            d0 = e0 ? 32'hA5A5_0008 : 32'h0;
            d1 = e0 ? 32'h0 : 32'hA5A5_0009;
            n_cmp++; if (m0_rvalid_o !== e0 || m1_rvalid_o !== ~e0 || m0_rdata_o !== d0 || m1_rdata_o !== d1) begin
               n_err++; $display("FAIL ct_rsp c%0d: got %b%b %h %h want %b%b %h %h", c, m1_rvalid_o, m0_rvalid_o, m0_rdata_o, m1_rdata_o, ~e0, e0, d0, d1); end
         end
      end
      idle();
   endtask

   task automatic test_write_then_read;
      lat = 4'd1;
      @(negedge clk); m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h8000_0000; m1_be_i = 4'hF; m1_wdata_i = 32'hCAFE_BABE; #1;
      n_cmp++; if (m1_gnt_o !== 1'b1 || sram_d_we_o !== 1'b1 || sram_d_wdata_o !== 32'hCAFE_BABE) begin n_err++; $display("FAIL wr_gnt: got %b/%b/%h want 1/1/cafebabe", m1_gnt_o, sram_d_we_o, sram_d_wdata_o); end
      @(negedge clk); m1_we_i = 1'b0; #1;
      n_cmp++; if (m1_gnt_o !== 1'b1) begin n_err++; $display("FAIL wr_rdgnt: got %b want 1", m1_gnt_o); end
      n_cmp++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'h0) begin n_err++; $display("FAIL wr_rsp: got %b/%h want 1/0", m1_rvalid_o, m1_rdata_o); end
      @(negedge clk); idle(); #1;
      n_cmp++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'hCAFE_BABE || m0_rvalid_o !== 1'b0) begin n_err++; $display("FAIL wr_rdback: got %b/%h m0 %b want 1/cafebabe m0 0", m1_rvalid_o, m1_rdata_o, m0_rvalid_o); end
   endtask

   task automatic test_rd_before_wr;
      lat = 4'd3;
      @(negedge clk); m0_req_i = 1'b1; m0_addr_i = 32'h8000_0014; #1;
      n_cmp++; if (m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL rw_rdgnt: got %b want 1", m0_gnt_o); end
      @(negedge clk); m0_we_i = 1'b1; m0_addr_i = 32'h8000_0018; m0_wdata_i = 32'h1122_3344; #1;
      n_cmp++; if (m0_gnt_o !== 1'b0 || sram_d_req_o !== 1'b0) begin n_err++; $display("FAIL rw_hold1: got %b/%b want 0/0", m0_gnt_o, sram_d_req_o); end
      @(negedge clk); #1;
      n_cmp++; if (m0_gnt_o !== 1'b0) begin n_err++; $display("FAIL rw_hold2: got %b want 0", m0_gnt_o); end
      @(negedge clk); #1;
      n_cmp++; if (m0_gnt_o !== 1'b1 || m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hA5A5_0005) begin n_err++; $display("FAIL rw_turn: got %b/%b/%h want 1/1/a5a50005", m0_gnt_o, m0_rvalid_o, m0_rdata_o); end
      @(negedge clk); idle(); #1;
      n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h0) begin n_err++; $display("FAIL rw_wrsp: got %b/%h want 1/0", m0_rvalid_o, m0_rdata_o); end
   endtask

   task automatic test_fifo_full;
      lat = 4'd4;
      @(negedge clk); m0_req_i = 1'b1; m0_addr_i = 32'h8000_0004; #1;
      n_cmp++; if (m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL ff_gnt0: got %b want 1", m0_gnt_o); end
      @(negedge clk); m0_addr_i = 32'h8000_0008; #1;
      n_cmp++; if (m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL ff_gnt1: got %b want 1", m0_gnt_o); end
      @(negedge clk); m0_addr_i = 32'h8000_000C; #1;
      n_cmp++; if (m0_gnt_o !== 1'b0) begin n_err++; $display("FAIL ff_full2: got %b want 0", m0_gnt_o); end
      @(negedge clk); #1;
      n_cmp++; if (m0_gnt_o !== 1'b0) begin n_err++; $display("FAIL ff_full3: got %b want 0", m0_gnt_o); end
      @(negedge clk); #1;
      n_cmp++; if (m0_gnt_o !== 1'b1 || m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hA5A5_0001) begin n_err++; $display("FAIL ff_pop: got %b/%b/%h want 1/1/a5a50001", m0_gnt_o, m0_rvalid_o, m0_rdata_o); end
      @(negedge clk); idle(); #1;
      n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hA5A5_0002) begin n_err++; $display("FAIL ff_rsp2: got %b/%h want 1/a5a50002", m0_rvalid_o, m0_rdata_o); end
      for (int c = 6; c < 8; c++) begin
         @(negedge clk); #1;
         n_cmp++; if (m0_rvalid_o !== 1'b0) begin n_err++; $display("FAIL ff_gap c%0d: got %b want 0", c, m0_rvalid_o); end
      end
      @(negedge clk); #1;
      n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hA5A5_0003) begin n_err++; $display("FAIL ff_rsp3: got %b/%h want 1/a5a50003", m0_rvalid_o, m0_rdata_o); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      lat = 4'd1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); m0_req_i = (c < 3); m0_addr_i = 32'h8000_0028 + 32'(4 * c); #1;
         if (c < 3) begin
            n_cmp++; if (m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL bb_gnt c%0d: got %b want 1", c, m0_gnt_o); end
         end
         if (c > 0) begin
            d = 32'hA5A5_0009 + 32'(c);
            n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== d) begin n_err++; $display("FAIL bb_rsp c%0d: got %b/%h want 1/%h", c, m0_rvalid_o, m0_rdata_o, d); end
         end
      end
      idle();
   endtask

   task automatic test_stray_reset;
      lat = 4'd3;
      @(negedge clk); m0_req_i = 1'b1; m0_addr_i = 32'h8000_0004; #1;
      n_cmp++; if (m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL st_gnt0: got %b want 1", m0_gnt_o); end
      @(negedge clk); m0_addr_i = 32'h8000_0008; #1;
      n_cmp++; if (m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL st_gnt1: got %b want 1", m0_gnt_o); end
      @(negedge clk); rst_i = 1'b1; idle();
      @(negedge clk); rst_i = 1'b0; #1;
      n_cmp++; if (sram_d_rvalid_i !== 1'b1 || m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || protocol_err_o !== 1'b0) begin
         n_err++; $display("FAIL st_c3: got srv %b rv %b%b perr %b want 1 00 0", sram_d_rvalid_i, m1_rvalid_o, m0_rvalid_o, protocol_err_o); end
      @(negedge clk); #1;
      n_cmp++; if (m0_rvalid_o !== 1'b0 || protocol_err_o !== 1'b1) begin n_err++; $display("FAIL st_c4: got rv %b perr %b want 0 1", m0_rvalid_o, protocol_err_o); end
      @(negedge clk); lat = 4'd1; #1;
      n_cmp++; if (protocol_err_o !== 1'b1) begin n_err++; $display("FAIL st_c5: got perr %b want 1", protocol_err_o); end
      @(negedge clk); m0_req_i = 1'b1; m0_addr_i = 32'h8000_001C; #1;
      n_cmp++; if (protocol_err_o !== 1'b0 || m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL st_c6: got perr %b gnt %b want 0 1", protocol_err_o, m0_gnt_o); end
      @(negedge clk); idle(); #1;
      n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hA5A5_0007 || protocol_err_o !== 1'b0) begin
         n_err++; $display("FAIL st_after: got %b/%h perr %b want 1/a5a50007 0", m0_rvalid_o, m0_rdata_o, protocol_err_o); end
   endtask

   initial begin
      rst_i = 1'b1; sram_d_gnt_i = 1'b1; lat = 4'd1; idle();
      test_reset();
      test_single_read();
      test_contention();
      test_write_then_read();
      test_rd_before_wr();
      test_fifo_full();
      test_back_to_back();
      test_stray_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
